// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM command encodings, controller state type and refresh-pending limits.
// Define SDRAM_REFRESH_BURST_EN to let one grant drain up to 8 owed refreshes.
package sdram_ctrl_pkg;

  typedef struct packed {
    logic cke;
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } sdram_cmds_t;

  localparam sdram_cmds_t CmdInhCkel = 5'b00111;
  localparam sdram_cmds_t CmdNop     = 5'b10111;
  localparam sdram_cmds_t CmdPre     = 5'b10010;
  localparam sdram_cmds_t CmdRef     = 5'b10001;
  localparam sdram_cmds_t CmdLmr     = 5'b10000;

  typedef enum logic [3:0] {
    StWaitPwr, StPreAll, StPreW, StIref, StIrefW, StLmr, StLmrW,
    StIdle, StReq, StRpre, StRpreW, StRref, StRrefW
  } state_e;

  localparam int unsigned PendW = 4;
`ifdef SDRAM_REFRESH_BURST_EN
  localparam int unsigned PendMax = 8;
  localparam bit          BurstEn = 1'b1;
`else
  localparam int unsigned PendMax = 1;
  localparam bit          BurstEn = 1'b0;
`endif

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer and owed-refresh counter with sticky overflow flag.
module sdram_ref_timer
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             ref_issue_i,
  output logic             tick_o,
  output logic [PendW-1:0] pending_o,
  output logic             err_o
);

  localparam int unsigned TimerW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TimerW-1:0] Reload = TimerW'(REF_INTERVAL - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [PendW-1:0]  pend_q, pend_d;
  logic              err_q, err_d;
  logic              tick;

  assign tick = run_i && (timer_q == '0);

  always_comb begin
    timer_d = timer_q;
    pend_d  = pend_q;
    err_d   = err_q;
    // Timer holds the reload value until init completes, so it starts on the first idle cycle.
    if (!run_i || tick) begin
      timer_d = Reload;
    end else begin
      timer_d = timer_q - TimerW'(1);
    end
    if (tick && !ref_issue_i) begin
      if (pend_q == PendW'(PendMax)) begin
        err_d = 1'b1;
      end else begin
        pend_d = pend_q + PendW'(1);
      end
    end else if (ref_issue_i && !tick && (pend_q != '0)) begin
      pend_d = pend_q - PendW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign tick_o    = tick;
  assign pending_o = pend_q;
  assign err_o     = err_q;

endmodule

// File: rtl/sdram_init_ref_ctrl.sv
// SDRAM power-up init sequencer and periodic auto-refresh requester, registered outputs.
// Refresh bursting is enabled by defining SDRAM_REFRESH_BURST_EN.
module sdram_init_ref_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned SDRAM_ADDR_SIZE = 13,
  parameter int unsigned SDRAM_BA_SIZE   = 2,
  parameter int unsigned INIT_WAIT       = 20000,
  parameter int unsigned TRP             = 3,
  parameter int unsigned TRFC            = 9,
  parameter int unsigned TMRD            = 2,
  parameter int unsigned INIT_REFRESHES  = 8,
  parameter int unsigned REF_INTERVAL    = 780
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [SDRAM_ADDR_SIZE-1:0] mode_i,
  input  logic                       ref_gnt_i,
  output sdram_cmds_t                cmd_o,
  output logic [SDRAM_BA_SIZE-1:0]   ba_o,
  output logic [SDRAM_ADDR_SIZE-1:0] addr_o,
  output logic                       init_done_o,
  output logic                       ref_req_o,
  output logic                       own_o,
  output logic                       ref_err_o
);

  localparam int unsigned CntW  = $clog2(INIT_WAIT + TRP + TRFC + TMRD + 1);
  localparam int unsigned IrefW = $clog2(INIT_REFRESHES + 2);

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [IrefW-1:0]           iref_q, iref_d;
  sdram_cmds_t                cmd_q, cmd_d;
  logic [SDRAM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic                       done_q, done_d, req_q, req_d, own_q, own_d;
  logic                       tick, owed;
  logic [PendW-1:0]           pending;

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .run_i       (done_q),
    .ref_issue_i (state_q == StRref),
    .tick_o      (tick),
    .pending_o   (pending),
    .err_o       (ref_err_o)
  );

  assign owed = (pending != '0) || tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    iref_d  = iref_q;
    unique case (state_q)
      StWaitPwr: if (cnt_q == CntW'(INIT_WAIT)) state_d = StPreAll;
      StPreAll: begin
        cnt_d   = CntW'(1);
        state_d = (TRP > 1) ? StPreW : StIref;
      end
      StPreW: if (cnt_q == CntW'(TRP - 1)) state_d = StIref;
      StIref: begin
        cnt_d   = CntW'(1);
        iref_d  = iref_q + IrefW'(1);
        state_d = (TRFC > 1) ? StIrefW :
                  (iref_d < IrefW'(INIT_REFRESHES)) ? StIref : StLmr;
      end
      StIrefW: begin
        if (cnt_q == CntW'(TRFC - 1)) begin
          state_d = (iref_q < IrefW'(INIT_REFRESHES)) ? StIref : StLmr;
        end
      end
      StLmr: begin
        cnt_d   = CntW'(1);
        state_d = (TMRD > 1) ? StLmrW : StIdle;
      end
      StLmrW: if (cnt_q == CntW'(TMRD - 1)) state_d = StIdle;
      StIdle: begin
        cnt_d = '0;
        if (owed) state_d = StReq;
      end
      StReq: begin
        cnt_d = '0;
        if (ref_gnt_i) state_d = StRpre;
      end
      StRpre: begin
        cnt_d   = CntW'(1);
        state_d = (TRP > 1) ? StRpreW : StRref;
      end
      StRpreW: if (cnt_q == CntW'(TRP - 1)) state_d = StRref;
      StRref: begin
        cnt_d   = CntW'(1);
        // The REF on the bus now is still counted in pending, hence > 1.
        state_d = (TRFC > 1) ? StRrefW :
                  (BurstEn && ((pending > PendW'(1)) || tick)) ? StRref : StIdle;
      end
      StRrefW: begin
        if (cnt_q == CntW'(TRFC - 1)) state_d = (BurstEn && owed) ? StRref : StIdle;
      end
      default: state_d = StWaitPwr;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    cmd_d  = CmdNop;
    addr_d = '0;
    unique case (state_d)
      StWaitPwr: cmd_d = (cnt_d == CntW'(INIT_WAIT)) ? CmdNop : CmdInhCkel;
      StPreAll, StRpre: begin
        cmd_d      = CmdPre;
        addr_d[10] = 1'b1;
      end
      StIref, StRref: cmd_d = CmdRef;
      StLmr: begin
        cmd_d  = CmdLmr;
        addr_d = mode_i;
      end
      default: ;
    endcase
    done_d = done_q || (state_d == StIdle);
    req_d  = (state_d == StReq);
    own_d  = (state_d inside {StRpre, StRpreW, StRref, StRrefW});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StWaitPwr;
      cnt_q   <= '0;
      iref_q  <= '0;
      cmd_q   <= CmdInhCkel;
      addr_q  <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iref_q  <= iref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      req_q   <= req_d;
      own_q   <= own_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign addr_o      = addr_q;
  assign ba_o        = '0;
  assign init_done_o = done_q;
  assign ref_req_o   = req_q;
  assign own_o       = own_q;

endmodule

// File: tb/tb_sdram_init_ref_ctrl.sv
// Bench for sdram_init_ref_ctrl: directed init/reset steps plus randomized grants
// checked against a command-schedule model of the init and refresh rules.
module tb_sdram_init_ref_ctrl;
  import sdram_ctrl_pkg::*;

  localparam int unsigned AW = 13, BW = 2, IW = 10, TRP = 2, TRFC = 4, TMRD = 2;
  localparam int unsigned IREFS = 2, RI = 50, NCYC = 1000;
`ifdef SDRAM_REFRESH_BURST_EN
  localparam int PMAX = 8;
  localparam bit BURST = 1'b1;
`else
  localparam int PMAX = 1;
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic [4:0]    c;
    logic [AW-1:0] a;
  } exp_t;

  logic          clk, rst_ni, gnt;
  logic [AW-1:0] mode, addr;
  logic [BW-1:0] ba;
  sdram_cmds_t   cmd;
  logic          init_done, ref_req, own, ref_err;

  int   n_tests = 0, n_fail = 0;
  exp_t iq[$];
  logic [4:0] bq[$];

  sdram_init_ref_ctrl #(
    .SDRAM_ADDR_SIZE (AW),
    .SDRAM_BA_SIZE   (BW),
    .INIT_WAIT       (IW),
    .TRP             (TRP),
    .TRFC            (TRFC),
    .TMRD            (TMRD),
    .INIT_REFRESHES  (IREFS),
    .REF_INTERVAL    (RI)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .mode_i      (mode),
    .ref_gnt_i   (gnt),
    .cmd_o       (cmd),
    .ba_o        (ba),
    .addr_o      (addr),
    .init_done_o (init_done),
    .ref_req_o   (ref_req),
    .own_o       (own),
    .ref_err_o   (ref_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] e_cmd, input logic [AW-1:0] e_addr,
                           input logic e_done, input logic e_req, input logic e_own,
                           input logic e_err);
    check({tag, ".cmd"}, 32'(cmd), 32'(e_cmd));
    check({tag, ".addr"}, 32'(addr), 32'(e_addr));
    check({tag, ".ba"}, 32'(ba), 32'd0);
    check({tag, ".done"}, 32'(init_done), 32'(e_done));
    check({tag, ".req"}, 32'(ref_req), 32'(e_req));
    check({tag, ".own"}, 32'(own), 32'(e_own));
    check({tag, ".err"}, 32'(ref_err), 32'(e_err));
  endtask

  function automatic exp_t mk(input logic [4:0] c, input logic [AW-1:0] a);
    exp_t e;
    e.c = c;
    e.a = a;
    return e;
  endfunction

  // Expected command on each cycle from reset release until the first idle cycle.
  task automatic build_init(input logic [AW-1:0] m);
    iq.delete();
    repeat (IW) iq.push_back(mk(CmdInhCkel, '0));
    iq.push_back(mk(CmdNop, '0));
    iq.push_back(mk(CmdPre, AW'(13'h400)));
    repeat (TRP - 1) iq.push_back(mk(CmdNop, '0));
    repeat (IREFS) begin
      iq.push_back(mk(CmdRef, '0));
      repeat (TRFC - 1) iq.push_back(mk(CmdNop, '0));
    end
    iq.push_back(mk(CmdLmr, m));
    repeat (TMRD - 1) iq.push_back(mk(CmdNop, '0));
  endtask

  task automatic run_init(input int n);
    for (int i = 0; i < n; i++) begin
      check_all($sformatf("init[%0d]", i), iq[i].c, iq[i].a, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_pre();
    bq.push_back(CmdPre);
    repeat (TRP - 1) bq.push_back(CmdNop);
  endtask

  task automatic push_ref();
    bq.push_back(CmdRef);
    repeat (TRFC - 1) bq.push_back(CmdNop);
  endtask

  // Grant policy per phase: directed pulse, random, tick-aligned REF, withheld, always on.
  function automatic logic grant_for(input int c);
    if (c < 60) return (c == 55);
    if (c < 400) return ($urandom_range(0, 3) == 0);
    if (c < 600) return ((c % RI) == (RI - 2 - TRP));
    if (c < 800) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int   pend;
    logic err, req, e_own, tick, issue, owed_now, g, last;
    logic [4:0] e_cmd;

    rst_ni = 1'b0;
    gnt    = 1'b0;
    mode   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all("por", CmdInhCkel, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start an init with a random mode and abort it during the initial-refresh wait.
    @(negedge clk);
    mode   = AW'($urandom_range(0, 8191));
    rst_ni = 1'b1;
    #1;
    build_init(mode);
    run_init(IW + 1 + TRP + TRFC);
    rst_ni = 1'b0;
    #1;
    check_all("mid_rst", CmdInhCkel, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_all("mid_rst_hold", CmdInhCkel, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    mode   = AW'(13'h033);
    rst_ni = 1'b1;
    #1;
    build_init(mode);
    run_init(iq.size());

    // Refresh phase: cycle c counts from the first idle cycle.
    pend = 0;
    err  = 1'b0;
    req  = 1'b0;
    bq.delete();
    for (int c = 0; c < NCYC; c++) begin
      e_own = (bq.size() != 0);
      e_cmd = e_own ? bq[0] : CmdNop;
      check_all($sformatf("ref[%0d]", c), e_cmd, (e_own && e_cmd == CmdPre) ? AW'(13'h400) : '0,
                1'b1, req, e_own, err);
      g   = grant_for(c);
      gnt = g;

      tick     = ((c % RI) == RI - 1);
      issue    = e_own && (e_cmd == CmdRef);
      owed_now = (pend > 0) || tick;
      if (e_own) begin
        last = (bq.size() == 1);
        void'(bq.pop_front());
        if (last && BURST && owed_now) push_ref();
      end else if (req) begin
        if (g) begin
          req = 1'b0;
          push_pre();
          push_ref();
        end
      end else if (owed_now) begin
        req = 1'b1;
      end
      if (tick && !issue) begin
        if (pend == PMAX) err = 1'b1;
        else pend++;
      end else if (issue && !tick && pend > 0) begin
        pend--;
      end

      @(negedge clk);
      #1;
    end
    gnt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
